mem_port_arbiter: RTL and testbench

//   Shares the single data-memory port between the IFU (instruction fetch, read-only) and the LSU
//   (loads/stores). Round-robin arbitration, one outstanding transaction, request payload held

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_rr_arb2.sv | 22 ++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic ID_IFU = 1'b0;
  localparam logic ID_LSU = 1'b1;

  localparam int MEM_ARB_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin selector; bit 0 = IFU, bit 1 = LSU.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o,
  output logic       id_o
);

  always_comb begin
    id_o = ID_IFU;
    unique case (1'b1)
      (req_i == 2'b11): id_o = ~last_i;
      (req_i == 2'b10): id_o = ID_LSU;
      (req_i == 2'b01): id_o = ID_IFU;
      default:          id_o = ID_IFU;
    endcase
    gnt_o = {id_o, ~id_o} & {2{|req_i}};
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between IFU and LSU: round-robin,
// one outstanding access, registered payload, timeout abort.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = MEM_ARB_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                ifu_req_i,
  input  logic [ADDR_W-1:0]   ifu_addr_i,
  output logic                ifu_gnt_o,
  output logic                ifu_rvalid_o,
  output logic [DATA_W-1:0]   ifu_rdata_o,
  output logic                ifu_err_o,
  input  logic                lsu_req_i,
  input  logic                lsu_we_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [DATA_W-1:0]   lsu_wdata_i,
  input  logic [DATA_W/8-1:0] lsu_wstrb_i,
  output logic                lsu_gnt_o,
  output logic                lsu_rvalid_o,
  output logic [DATA_W-1:0]   lsu_rdata_o,
  output logic                lsu_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  arb_state_e state_q, state_d;
  logic owner_q, owner_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;

  logic [1:0] arb_gnt;
  logic arb_id;
  logic grant, done, abort, rsp;
  logic [DATA_W-1:0] rdata;

  rr_arb2 u_arb (
    .req_i  ({lsu_req_i, ifu_req_i}),
    .last_i (last_q),
    .gnt_o  (arb_gnt),
    .id_o   (arb_id)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= ID_IFU;
      last_q  <= ID_IFU;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    grant   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ifu_req_i || lsu_req_i) begin
          grant   = 1'b1;
          owner_d = arb_id;
          cnt_d   = '0;
          state_d = REQ;
          if (arb_id == ID_LSU) begin
            we_d    = lsu_we_i;
            addr_d  = lsu_addr_i;
            wdata_d = lsu_wdata_i;
            wstrb_d = lsu_we_i ? lsu_wstrb_i : '0;
          end else begin
            we_d    = 1'b0;
            addr_d  = ifu_addr_i;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      REQ: begin
        done = mem_gnt_i && mem_rvalid_i;
        if (mem_gnt_i) state_d = RESP;
      end
      RESP: done = mem_rvalid_i;
      default: state_d = IDLE;
    endcase
    // Completion beats timeout when both land in the same cycle.
    if (state_q != IDLE) begin
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + CW'(1);
      abort = !done && (cnt_q == CNT_LAST);
      if (done || abort) begin
        state_d = IDLE;
        last_d  = owner_q;
      end
    end
  end

  assign rsp   = done || abort;
  assign rdata = done ? mem_rdata_i : '0;

  assign ifu_gnt_o    = grant && arb_gnt[0] && rst_n_i;
  assign lsu_gnt_o    = grant && arb_gnt[1] && rst_n_i;
  assign ifu_rvalid_o = rsp && (owner_q == ID_IFU);
  assign lsu_rvalid_o = rsp && (owner_q == ID_LSU);
  assign ifu_err_o    = abort && (owner_q == ID_IFU);
  assign lsu_err_o    = abort && (owner_q == ID_LSU);
  assign ifu_rdata_o  = (owner_q == ID_IFU) ? rdata : '0;
  assign lsu_rdata_o  = (owner_q == ID_LSU) ? rdata : '0;

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_i;
  logic [31:0] ifu_addr_i;
  logic        ifu_gnt_o, ifu_rvalid_o, ifu_err_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic [3:0]  lsu_wstrb_i;
  logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i),
    .ifu_gnt_o(ifu_gnt_o), .ifu_rvalid_o(ifu_rvalid_o),
    .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_wstrb_i(lsu_wstrb_i),
    .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
    .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ifu;
    logic        lsu;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } pay_t;

  logic [1:0] gq[$];
  pay_t       pq[$];
  rsp_t       rq[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_last;
  logic late;
  pay_t mp;
  rsp_t mr;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ifu_gnt_o || lsu_gnt_o) begin
        if (gq.size() == 0) chk("gnt_unexp", {ifu_gnt_o, lsu_gnt_o}, 0);
        else chk("gnt", {ifu_gnt_o, lsu_gnt_o}, gq.pop_front());
      end
      if (mem_req_o) begin
        if (pq.size() == 0) chk("mreq_unexp", mem_req_o, 0);
        else begin
          mp = pq[0];
          chk("m_we", mem_we_o, mp.we);
          chk("m_addr", mem_addr_o, mp.addr);
          chk("m_wdata", mem_wdata_o, mp.wdata);
          chk("m_wstrb", mem_wstrb_o, mp.wstrb);
        end
      end
      if (ifu_rvalid_o || lsu_rvalid_o) begin
        if (pq.size() != 0) void'(pq.pop_front());
        if (rq.size() == 0) chk("rsp_unexp", {ifu_rvalid_o, lsu_rvalid_o}, 0);
        else begin
          mr = rq.pop_front();
          chk("rvalid", {ifu_rvalid_o, lsu_rvalid_o}, {mr.ifu, mr.lsu});
          chk("err", mr.lsu ? lsu_err_o : ifu_err_o, mr.err);
          chk("rdata", mr.lsu ? lsu_rdata_o : ifu_rdata_o, mr.data);
          chk("other_rdata", mr.lsu ? ifu_rdata_o : lsu_rdata_o, 0);
          chk("other_err", mr.lsu ? ifu_err_o : lsu_err_o, 0);
        end
      end
    end
  end

  task automatic clr_mem();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
  endtask

  task automatic do_reset_mid();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {ifu_gnt_o, ifu_rvalid_o, ifu_err_o, lsu_gnt_o,
                    lsu_rvalid_o, lsu_err_o, mem_req_o, mem_we_o}, 0);
    chk("rst_rdata", {ifu_rdata_o, lsu_rdata_o}, 0);
    chk("rst_pay", {mem_addr_o, mem_wdata_o}, 0);
    chk("rst_strb", mem_wstrb_o, 0);
    gq.delete(); pq.delete(); rq.delete();
    ifu_req_i = 1'b0;
    lsu_req_i = 1'b0;
    m_last = 1'b0;
    late = 1'b0;
    clr_mem();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_gnt", {ifu_gnt_o, lsu_gnt_o, mem_req_o}, 0);
    end
    @(posedge clk); #1;
  endtask

  // One arbitration round; g = cycle of mem_gnt_i, r = extra cycles to rvalid.
  task automatic xact(input bit ri, input bit rl, input logic [31:0] ia,
                      input bit lwe, input logic [31:0] la,
                      input logic [31:0] lwd, input logic [3:0] lst,
                      input int g, input int r, input logic [31:0] d,
                      input int rk);
    bit w, e;
    int c, cend;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = late;
    mem_rdata_i  = $urandom;
    late = 1'b0;
    if (ri && !ifu_req_i) begin
      ifu_req_i  = 1'b1;
      ifu_addr_i = ia;
    end
    if (rl && !lsu_req_i) begin
      lsu_req_i   = 1'b1;
      lsu_we_i    = lwe;
      lsu_addr_i  = la;
      lsu_wdata_i = lwd;
      lsu_wstrb_i = lst;
    end
    if (!ifu_req_i && !lsu_req_i) begin
      @(negedge clk);
      chk("idle_mreq", mem_req_o, 0);
      @(posedge clk); #1;
      clr_mem();
      return;
    end
    w = (ifu_req_i && lsu_req_i) ? !m_last : lsu_req_i;
    c = g + r;
    e = (c > TO - 1);
    gq.push_back(w ? 2'b01 : 2'b10);
    if (w) pq.push_back(pay_t'{lsu_we_i, lsu_addr_i, lsu_wdata_i,
                               lsu_we_i ? lsu_wstrb_i : 4'h0});
    else pq.push_back(pay_t'{1'b0, ifu_addr_i, 32'h0, 4'h0});
    rq.push_back(rsp_t'{!w, w, e, e ? 32'h0 : d});
    m_last = w;
    @(posedge clk); #1;
    if (w) lsu_req_i = 1'b0;
    else ifu_req_i = 1'b0;
    cend = (c < TO - 1) ? c : TO - 1;
    for (int k = 0; k <= cend; k++) begin
      mem_gnt_i    = (k == g);
      mem_rvalid_i = (k == c);
      mem_rdata_i  = (k == c) ? d : $urandom;
      if (k == rk) begin
        do_reset_mid();
        return;
      end
      @(negedge clk);
      chk("mreq_lvl", mem_req_o, (k <= g));
      @(posedge clk); #1;
    end
    clr_mem();
    late = e;
  endtask

  initial begin
    bit b_i, b_l, we;
    int g, r, rk;
    rst_n = 1'b0;
    ifu_req_i = 1'b1; ifu_addr_i = '0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0; lsu_wstrb_i = '0;
    clr_mem();
    m_last = 1'b0;
    late = 1'b0;
    #1;
    chk("rst0_ctl", {ifu_gnt_o, ifu_rvalid_o, ifu_err_o, lsu_gnt_o,
                     lsu_rvalid_o, lsu_err_o, mem_req_o, mem_we_o}, 0);
    chk("rst0_pay", {mem_addr_o, mem_wdata_o}, 0);
    ifu_req_i = 1'b0;
    lsu_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    xact(1, 0, 32'h8000_0000, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, -1);
    for (int i = 0; i < 4; i++)
      xact(1, 1, 32'h100 + i, 0, 32'h200 + i, 0, 4'hF, 0, 1, 32'hA0 + i, -1);
    xact(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hB0, -1);
    xact(0, 1, 0, 1, 32'h10, 32'h1234_5678, 4'b0011, 5, 1, 32'hC0, -1);
    xact(0, 1, 0, 0, 32'h20, 0, 4'hF, 0, 0, 32'h5555_AAAA, -1);
    xact(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, -1);
    xact(1, 0, 32'h44, 0, 0, 0, 0, 100, 0, 32'h0BAD, -1);
    xact(0, 1, 0, 1, 32'h48, 32'h77, 4'h1, 3, 10, 32'h0BAD, -1);
    xact(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, -1);
    xact(1, 0, 32'h4C, 0, 0, 0, 0, 2, 5, 32'h0EEE, -1);
    xact(0, 1, 0, 0, 32'h60, 0, 0, 1, 5, 32'h1111, 3);
    xact(1, 1, 32'h64, 0, 32'h68, 0, 4'hF, 0, 1, 32'h2222, -1);
    xact(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3333, -1);

    for (int it = 0; it < 300; it++) begin
      b_i = ($urandom % 2) == 1;
      b_l = ($urandom % 2) == 1;
      we  = ($urandom % 2) == 1;
      g   = (($urandom % 8) == 0) ? 12 : int'($urandom % 6);
      r   = (($urandom % 8) == 0) ? 9 : int'($urandom % 3);
      rk  = (($urandom % 40) == 0) ? 0 : -1;
      xact(b_i, b_l, $urandom, we, $urandom, we ? $urandom : 32'h0,
           4'($urandom), g, r, $urandom, rk);
    end
    repeat (3) xact(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4444, -1);

    @(negedge clk);
    chk("gq_left", gq.size(), 0);
    chk("pq_left", pq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
